// File: rtl/wdt_pkg.sv
// Shared types and constants for the watchdog timer block.
package wdt_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      FIRE  = 2'd2
   } wdt_state_e;

   localparam logic [1:0] WDT_ADDR_WDEN   = 2'd0;
   localparam logic [1:0] WDT_ADDR_WDLIVE = 2'd1;
   localparam logic [1:0] WDT_ADDR_WTOCNT = 2'd2;
   localparam logic [1:0] WDT_ADDR_CNT    = 2'd3;

   localparam int WDT_HOLD_LEN_DEF = 4;

endpackage

// File: rtl/wdt_if.sv
// Register port of the watchdog: single write strobe plus a combinational read.
interface wdt_if;

   logic        wdt_wr;
   logic [1:0]  wdt_addr;
   logic [31:0] wdt_wdata;
   logic [31:0] wdt_rdata;

   modport master (
      output wdt_wr,
      output wdt_addr,
      output wdt_wdata,
      input  wdt_rdata
   );

   modport slave (
      input  wdt_wr,
      input  wdt_addr,
      input  wdt_wdata,
      output wdt_rdata
   );

endinterface

// File: rtl/wdt_regs.sv
// Watchdog register file: WDEN/WTOCNT storage, WDLIVE kick decode and read mux.
module wdt_regs
   import wdt_pkg::*;
#(
   parameter int               CNT_W      = 32,
   parameter logic [CNT_W-1:0] RST_WTOCNT = {CNT_W{1'b1}}
) (
   input  logic             clk,
   input  logic             rst,
   wdt_if.slave             bus,
   input  logic [CNT_W-1:0] i_cnt,
   output logic             o_wden,
   output logic [CNT_W-1:0] o_wtocnt,
   output logic             o_kick
);

   logic             r_wden;
   logic [CNT_W-1:0] r_wtocnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wden   <= 1'b0;
         r_wtocnt <= RST_WTOCNT;
      end else if (bus.wdt_wr) begin
         if (bus.wdt_addr == WDT_ADDR_WDEN) begin
            r_wden <= bus.wdt_wdata[0];
         end else if (bus.wdt_addr == WDT_ADDR_WTOCNT) begin
            r_wtocnt <= bus.wdt_wdata[CNT_W-1:0];
         end
      end
   end

   // WDLIVE has no storage; writing a 1 to bit 0 is purely a kick pulse
   assign o_kick   = bus.wdt_wr && (bus.wdt_addr == WDT_ADDR_WDLIVE) && bus.wdt_wdata[0];
   assign o_wden   = r_wden;
   assign o_wtocnt = r_wtocnt;

   always_comb begin
      bus.wdt_rdata = '0;
      case (bus.wdt_addr)
         WDT_ADDR_WDEN:   bus.wdt_rdata[0]       = r_wden;
         WDT_ADDR_WTOCNT: bus.wdt_rdata[CNT_W-1:0] = r_wtocnt;
         WDT_ADDR_CNT:    bus.wdt_rdata[CNT_W-1:0] = i_cnt;
         default:         bus.wdt_rdata          = '0;
      endcase
   end

endmodule

// File: rtl/wdt_timer.sv
// Watchdog timer top: expiry FSM and counter driving the CPU timeout input.
// Optional WDT_PREWARN_EN adds a registered half-way warning output 'prewarn'.
module wdt_timer
   import wdt_pkg::*;
#(
   parameter int               CNT_W      = 32,
   parameter int               HOLD_LEN   = WDT_HOLD_LEN_DEF,
   parameter logic [CNT_W-1:0] RST_WTOCNT = {CNT_W{1'b1}}
) (
   input  logic       clk,
   input  logic       rst,
   wdt_if.slave       bus,
   output logic       timeout,
   output logic [1:0] wdt_state
`ifdef WDT_PREWARN_EN
   ,output logic      prewarn
`endif
);

   localparam int               HOLD_W    = (HOLD_LEN > 1) ? $clog2(HOLD_LEN) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_LEN - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

   wdt_state_e        r_state;
   wdt_state_e        w_stateNext;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cntNext;
   logic [HOLD_W-1:0] r_hold;
   logic [HOLD_W-1:0] w_holdNext;
   logic              r_timeout;
   logic              w_wden;
   logic              w_kick;
   logic [CNT_W-1:0]  w_wtocnt;

   wdt_regs #(
      .CNT_W      (CNT_W),
      .RST_WTOCNT (RST_WTOCNT)
   ) u_regs (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .i_cnt    (r_cnt),
      .o_wden   (w_wden),
      .o_wtocnt (w_wtocnt),
      .o_kick   (w_kick)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_hold    <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_stateNext;
         r_cnt     <= w_cntNext;
         r_hold    <= w_holdNext;
         r_timeout <= (w_stateNext == FIRE);
      end
   end

   // In COUNT, disable beats kick, and kick beats expiry in the same cycle
   always_comb begin
      w_stateNext = r_state;
      w_cntNext   = r_cnt;
      w_holdNext  = r_hold;
      case (r_state)
         IDLE: begin
            w_cntNext  = '0;
            w_holdNext = '0;
            if (w_wden) begin
               w_stateNext = COUNT;
            end
         end
         COUNT: begin
            w_holdNext = '0;
            if (!w_wden) begin
               w_stateNext = IDLE;
               w_cntNext   = '0;
            end else if (w_kick) begin
               w_cntNext = '0;
            end else if (r_cnt >= w_wtocnt) begin
               w_stateNext = FIRE;
               w_cntNext   = '0;
            end else if (r_cnt != CNT_MAX) begin
               w_cntNext = r_cnt + 1'b1;
            end
         end
         FIRE: begin
            w_cntNext = '0;
            if (!w_wden) begin
               w_stateNext = IDLE;
               w_holdNext  = '0;
            end else if (r_hold == HOLD_LAST) begin
               w_stateNext = COUNT;
               w_holdNext  = '0;
            end else begin
               w_holdNext = r_hold + 1'b1;
            end
         end
         default: begin
            w_stateNext = IDLE;
            w_cntNext   = '0;
            w_holdNext  = '0;
         end
      endcase
   end

   assign timeout   = r_timeout;
   assign wdt_state = r_state;

`ifdef WDT_PREWARN_EN
   logic r_prewarn;

   // Evaluated on next-cycle values so the flag tracks state/cnt with no lag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_prewarn <= 1'b0;
      end else begin
         r_prewarn <= (w_stateNext == COUNT) && !w_kick && (w_cntNext >= (w_wtocnt >> 1));
      end
   end

   assign prewarn = r_prewarn;
`endif

endmodule

// File: tb/tb_wdt_timer.sv
// Directed scoreboard bench for wdt_timer: expiry timing, kicks, abort and reset paths.
module tb_wdt_timer;
   import wdt_pkg::*;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } expEntry_t;

   logic       clk;
   logic       rst;
   logic       timeout;
   logic [1:0] wdt_state;
`ifdef WDT_PREWARN_EN
   logic       prewarn;
`endif

   int          assertCount;
   int          failCount;
   expEntry_t   sbQ[$];

   wdt_if bus();

   wdt_timer dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .timeout   (timeout),
      .wdt_state (wdt_state)
`ifdef WDT_PREWARN_EN
      ,.prewarn  (prewarn)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] time limit");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [1:0] addr, input logic [31:0] data);
      bus.wdt_wr    = 1'b1;
      bus.wdt_addr  = addr;
      bus.wdt_wdata = data;
      tick();
      bus.wdt_wr    = 1'b0;
      bus.wdt_wdata = '0;
   endtask

   task automatic readReg(input logic [1:0] addr, output logic [31:0] val);
      bus.wdt_addr = addr;
      #1;
      val = bus.wdt_rdata;
   endtask

   task automatic pushExpected(input string tag, input logic [31:0] val);
      expEntry_t e;
      e.tag = tag;
      e.val = val;
      sbQ.push_back(e);
   endtask

   task automatic checkOutput(input logic [31:0] obs);
      expEntry_t e;
      assertCount++;
      if (sbQ.size() == 0) begin
         failCount++;
         $display("[TB] FAIL scoreboard_empty observed=%0h expected=<entry>", obs);
      end else begin
         e = sbQ.pop_front();
         assert (obs === e.val) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic waitEnterCount();
      int k;
      k = 0;
      while (wdt_state != COUNT && k < 20) begin
         tick();
         k++;
      end
      pushExpected("enter_count", 32'(COUNT));
      checkOutput({30'b0, wdt_state});
   endtask

   initial begin
      logic [31:0] v;
      logic [31:0] maxCnt;
      logic        sawTimeout;
      int          k;

      assertCount   = 0;
      failCount     = 0;
      rst           = 1'b0;
      bus.wdt_wr    = 1'b0;
      bus.wdt_addr  = '0;
      bus.wdt_wdata = '0;
      $display("[TB] start");

      tick();
      tick();
      pushExpected("rst_timeout", 0);
      checkOutput({31'b0, timeout});
      pushExpected("rst_state", 32'(IDLE));
      checkOutput({30'b0, wdt_state});
      readReg(WDT_ADDR_WDEN, v);
      pushExpected("rst_wden", 0);
      checkOutput(v);
      readReg(WDT_ADDR_WTOCNT, v);
      pushExpected("rst_wtocnt", 32'hFFFF_FFFF);
      checkOutput(v);
      readReg(WDT_ADDR_CNT, v);
      pushExpected("rst_cnt", 0);
      checkOutput(v);
      rst = 1'b1;
      tick();

      // Expiry with WTOCNT=5: fires N+1 edges after entering COUNT, holds 4 cycles
      applyStimulus(WDT_ADDR_WTOCNT, 32'd5);
      readReg(WDT_ADDR_WTOCNT, v);
      pushExpected("wtocnt_rd", 32'd5);
      checkOutput(v);
      readReg(WDT_ADDR_WDLIVE, v);
      pushExpected("wdlive_rd", 0);
      checkOutput(v);
      applyStimulus(WDT_ADDR_WDEN, 32'd1);
      waitEnterCount();
      k = 0;
      while (!timeout && k < 50) begin
         tick();
         k++;
      end
      pushExpected("fire_latency", 32'd6);
      checkOutput(32'(k));
      pushExpected("state_fire", 32'(FIRE));
      checkOutput({30'b0, wdt_state});
      k = 0;
      while (timeout && k < 20) begin
         tick();
         k++;
      end
      pushExpected("hold_len", 32'd4);
      checkOutput(32'(k));
      pushExpected("state_rearm", 32'(COUNT));
      checkOutput({30'b0, wdt_state});
      readReg(WDT_ADDR_CNT, v);
      pushExpected("cnt_restart", 0);
      checkOutput(v);

      // Periodic kicks every 8 cycles keep the watchdog quiet
      applyStimulus(WDT_ADDR_WTOCNT, 32'd10);
      maxCnt     = '0;
      sawTimeout = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (i % 8 == 0) begin
            applyStimulus(WDT_ADDR_WDLIVE, 32'd1);
         end else begin
            bus.wdt_addr = WDT_ADDR_CNT;
            tick();
            if (bus.wdt_rdata > maxCnt) maxCnt = bus.wdt_rdata;
         end
         if (timeout) sawTimeout = 1'b1;
      end
      pushExpected("kick_no_timeout", 0);
      checkOutput({31'b0, sawTimeout});
      pushExpected("kick_cnt_max", 32'd7);
      checkOutput(maxCnt);

      // Kick in the very cycle cnt equals WTOCNT must beat expiry
      readReg(WDT_ADDR_CNT, v);
      k = 0;
      while (bus.wdt_rdata != 32'd10 && k < 40) begin
         tick();
         k++;
      end
      pushExpected("cnt_at_limit", 32'd10);
      checkOutput(bus.wdt_rdata);
      applyStimulus(WDT_ADDR_WDLIVE, 32'd1);
      pushExpected("kick_limit_timeout", 0);
      checkOutput({31'b0, timeout});
      pushExpected("kick_limit_state", 32'(COUNT));
      checkOutput({30'b0, wdt_state});
      readReg(WDT_ADDR_CNT, v);
      pushExpected("kick_limit_cnt", 0);
      checkOutput(v);

      // Disable during the second FIRE cycle aborts the hold
      k = 0;
      while (!timeout && k < 40) begin
         tick();
         k++;
      end
      pushExpected("fire_again", 1);
      checkOutput({31'b0, timeout});
      tick();
      pushExpected("fire_cycle2", 32'(FIRE));
      checkOutput({30'b0, wdt_state});
      applyStimulus(WDT_ADDR_WDEN, 32'd0);
      tick();
      pushExpected("abort_timeout", 0);
      checkOutput({31'b0, timeout});
      pushExpected("abort_state", 32'(IDLE));
      checkOutput({30'b0, wdt_state});
      readReg(WDT_ADDR_CNT, v);
      pushExpected("abort_cnt", 0);
      checkOutput(v);

      // Asynchronous reset mid-COUNT
      applyStimulus(WDT_ADDR_WTOCNT, 32'd20);
      applyStimulus(WDT_ADDR_WDEN, 32'd1);
      readReg(WDT_ADDR_CNT, v);
      k = 0;
      while (bus.wdt_rdata != 32'd7 && k < 40) begin
         tick();
         k++;
      end
      pushExpected("cnt_seven", 32'd7);
      checkOutput(bus.wdt_rdata);
      rst = 1'b0;
      #1;
      pushExpected("arst_timeout", 0);
      checkOutput({31'b0, timeout});
      pushExpected("arst_state", 32'(IDLE));
      checkOutput({30'b0, wdt_state});
      readReg(WDT_ADDR_WDEN, v);
      pushExpected("arst_wden", 0);
      checkOutput(v);
      readReg(WDT_ADDR_WTOCNT, v);
      pushExpected("arst_wtocnt", 32'hFFFF_FFFF);
      checkOutput(v);
      readReg(WDT_ADDR_CNT, v);
      pushExpected("arst_cnt", 0);
      checkOutput(v);
      tick();
      rst = 1'b1;
      tick();

      // WTOCNT=0 fires one edge after entry; reset then drops timeout at once
      applyStimulus(WDT_ADDR_WTOCNT, 32'd0);
      applyStimulus(WDT_ADDR_WDEN, 32'd1);
      waitEnterCount();
      k = 0;
      while (!timeout && k < 20) begin
         tick();
         k++;
      end
      pushExpected("fire_latency_n0", 32'd1);
      checkOutput(32'(k));
      rst = 1'b0;
      #1;
      pushExpected("arst_fire_timeout", 0);
      checkOutput({31'b0, timeout});
      tick();
      rst = 1'b1;
      tick();

`ifdef WDT_PREWARN_EN
      // Prewarn rises at half of WTOCNT and clears on a kick
      applyStimulus(WDT_ADDR_WTOCNT, 32'd20);
      applyStimulus(WDT_ADDR_WDEN, 32'd1);
      waitEnterCount();
      readReg(WDT_ADDR_CNT, v);
      sawTimeout = 1'b0;
      k = 0;
      while (bus.wdt_rdata < 32'd10 && k < 40) begin
         if (prewarn) sawTimeout = 1'b1;
         tick();
         k++;
      end
      pushExpected("prewarn_early", 0);
      checkOutput({31'b0, sawTimeout});
      pushExpected("prewarn_cnt", 32'd10);
      checkOutput(bus.wdt_rdata);
      pushExpected("prewarn_rise", 1);
      checkOutput({31'b0, prewarn});
      applyStimulus(WDT_ADDR_WDLIVE, 32'd1);
      pushExpected("prewarn_kick", 0);
      checkOutput({31'b0, prewarn});
      pushExpected("prewarn_timeout", 0);
      checkOutput({31'b0, timeout});
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
